traffic_light_ctrl: RTL
=======================

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, Sys_CLK cycles per one-second tick.
REQ-002 Parameter GREEN_SEC, default 30, green phase duration in seconds; legal range 1..99.
REQ-003 Parameter YELLOW_SEC, default 3, yellow phase duration in seconds; legal range 1..99.
REQ-004 Parameter RED_SEC, default 30, red phase duration in seconds; legal range 1..99.
REQ-005 Sys_CLK  in  1  the only clock; all state changes on its rising edge.
REQ-006 Sys_RST  in  1  reset, synchronous, active-high.
REQ-007 Pause  in  1  while 1, freezes the countdown and the phase.
REQ-008 Night  in  1  while 1, selects flashing-yellow mode.
REQ-009 count  out  20  seconds remaining in the current phase, binary; feeds the nixie-tube display stage.
REQ-010 state  out  1  1 = normal cycling, countdown valid; 0 = flash mode, display to be blanked.
REQ-011 Light  out  3  lamp drive {R,Y,G}, one-hot or all-zero.
REQ-012 Sec_Tick  out  1  one-cycle pulse marking each counted second.

Function
REQ-013 Prescaler counts 0..CLK_HZ-1 and wraps; Sec_Tick = (prescaler==CLK_HZ-1) && !Pause, combinational from registered state.
REQ-014 While Pause=1 and Night=0: prescaler, count, phase and Light hold; on release, counting resumes from the held prescaler value.
REQ-015 FSM states: GREEN, YELLOW, RED, FLASH; Light = 001, 010, 100 for GREEN/YELLOW/RED respectively.
REQ-016 On a Sec_Tick edge with count>1: count decrements by 1, phase unchanged.
REQ-017 On a Sec_Tick edge with count==1: transition GREEN->YELLOW->RED->GREEN and load count with the new phase's duration on that same edge; count therefore shows N..1, never 0, in normal mode.
REQ-018 Night=1 sampled at any edge: enter FLASH on that edge from any state; count=0, state=0, Light=010, prescaler cleared.
REQ-019 In FLASH, Light toggles between 010 and 000 on each Sec_Tick edge.
REQ-020 Night 1->0: on the first edge with Night=0 in FLASH, enter RED, count=RED_SEC, state=1, prescaler cleared.
REQ-021 Priority: Sys_RST > Night > Pause > tick.
REQ-022 count[19:7] always zero; count never exceeds 99.
REQ-023 All outputs except Sec_Tick are registered; zero additional latency beyond the tick edge.

Reset
REQ-024 On Sys_RST=1 at an edge: phase=GREEN, count=GREEN_SEC, state=1, Light=001, prescaler=0, FLASH toggle=0; applies mid-phase and regardless of Pause/Night.

Structure
REQ-025 Phase encodings, Light encodings and default durations SHALL reside in shared include file traffic_pkg.
REQ-026 The prescaler and Sec_Tick generation SHALL be sub-module sec_tick (ports Sys_CLK, Sys_RST, Hold, Clr, Tick).

Verification (CLK_HZ=4, GREEN_SEC=3, YELLOW_SEC=2, RED_SEC=3)
REQ-027 Reset released -> count=3, Light=001, state=1; 4 clocks later count=2.
REQ-028 Free run from reset -> count sequence 3,2,1 (001), 2,1 (010), 3,2,1 (100), then 3 with Light=001 at clock 32.
REQ-029 Pause=1 for 10 cycles at prescaler=2 mid-green -> count, Light, prescaler hold; next tick occurs 2 cycles after release.
REQ-030 Night=1 in YELLOW -> next edge: count=0, state=0, Light=010, then toggles every 4 clocks; Night=0 -> RED, count=3, state=1.
REQ-031 Night=1 and Pause=1 together -> FLASH entered, Light toggling continues.
REQ-032 Sys_RST=1 mid-RED with Pause=1 -> next edge GREEN, count=3, Light=001.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller: phase encodings,
// lamp encodings, default durations and small helpers.
// Ports: none (package).
package traffic_pkg;

  // Controller phases; FLASH is the night-time blinking-yellow mode.
  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_RED    = 2'd2,
    PH_FLASH  = 2'd3
  } phase_t;

  // Lamp drive encodings, bit order {R,Y,G}.
  localparam logic [2:0] LIGHT_OFF    = 3'b000;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED    = 3'b100;

  // Default timing: one tick per second of a 50 MHz clock.
  localparam int DEF_CLK_HZ     = 50_000_000;
  localparam int DEF_GREEN_SEC  = 30;
  localparam int DEF_YELLOW_SEC = 3;
  localparam int DEF_RED_SEC    = 30;

  // Durations never exceed 99, so 7 bits hold the live countdown; the
  // display-facing count is zero-extended to 20 bits.
  localparam int CNT_W   = 7;
  localparam int COUNT_W = 20;

  // Normal-mode rotation order.
  function automatic phase_t next_phase(input phase_t p);
    case (p)
      PH_GREEN:  return PH_YELLOW;
      PH_YELLOW: return PH_RED;
      default:   return PH_GREEN;
    endcase
  endfunction

  // Steady lamp pattern of a normal-mode phase.
  function automatic logic [2:0] phase_light(input phase_t p);
    case (p)
      PH_GREEN:  return LIGHT_GREEN;
      PH_YELLOW: return LIGHT_YELLOW;
      PH_RED:    return LIGHT_RED;
      default:   return LIGHT_YELLOW;
    endcase
  endfunction

  // Narrow a duration in seconds to the countdown width.
  function automatic logic [CNT_W-1:0] sec_to_cnt(input int sec);
    return sec[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Control/status bundle between the traffic light controller and its user.
// Ports: Pause, Night (user -> controller); count, state, Light, Sec_Tick
// (controller -> user). master = user side, slave = controller side.
interface traffic_light_ctrl_if;

  logic        Pause;     // freeze countdown and phase
  logic        Night;     // select flashing-yellow mode
  logic [19:0] count;     // seconds remaining, binary, 0 in flash mode
  logic        state;     // 1 = normal cycling, 0 = flash (blank display)
  logic [2:0]  Light;     // lamp drive {R,Y,G}
  logic        Sec_Tick;  // one-cycle pulse per counted second

  modport master (
    output Pause,
    output Night,
    input  count,
    input  state,
    input  Light,
    input  Sec_Tick
  );

  modport slave (
    input  Pause,
    input  Night,
    output count,
    output state,
    output Light,
    output Sec_Tick
  );

endinterface

// File: rtl/sec_tick.sv
// One-second prescaler: counts 0..CLK_HZ-1 and flags the last count.
// Latency: Tick is combinational from the registered prescaler (no extra cycle).
// Hold freezes the prescaler and masks Tick; Clr zeroes it and wins over Hold.
// Ports: Sys_CLK, Sys_RST (sync, active-high), Hold, Clr in; Tick out.
module sec_tick #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic Sys_CLK,
  input  logic Sys_RST,
  input  logic Hold,
  input  logic Clr,
  output logic Tick
);

  // A 1 Hz clock still needs a 1-bit register to keep the code uniform.
  localparam int         PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc;

  always_ff @(posedge Sys_CLK) begin
    if (Sys_RST) begin
      presc <= '0;
    end else if (Clr) begin
      presc <= '0;
    end else if (!Hold) begin
      presc <= (presc == LAST) ? '0 : presc + 1'b1;
    end
  end

  assign Tick = (presc == LAST) && !Hold;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Traffic light controller: GREEN->YELLOW->RED rotation with per-second
// countdown, pause, and a night flashing-yellow mode.
// Latency: count/state/Light change on the same edge that sees the tick or
// mode input; Sec_Tick is combinational from the prescaler register.
// Ports: Sys_CLK, Sys_RST (sync, active-high) plain; bus (slave modport)
// carries Pause, Night in and count, state, Light, Sec_Tick out.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int CLK_HZ     = DEF_CLK_HZ,
  parameter int GREEN_SEC  = DEF_GREEN_SEC,
  parameter int YELLOW_SEC = DEF_YELLOW_SEC,
  parameter int RED_SEC    = DEF_RED_SEC
) (
  input  logic                 Sys_CLK,
  input  logic                 Sys_RST,
  traffic_light_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] GREEN_CNT  = sec_to_cnt(GREEN_SEC);
  localparam logic [CNT_W-1:0] YELLOW_CNT = sec_to_cnt(YELLOW_SEC);
  localparam logic [CNT_W-1:0] RED_CNT    = sec_to_cnt(RED_SEC);

  phase_t           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]       light_q, light_d;
  logic             state_q, state_d;
  logic             blink_q, blink_d;   // 1 = lamp dark in the current flash second

  logic in_flash;
  logic hold;
  logic clr;
  logic tick;
  phase_t nxt;

  function automatic logic [CNT_W-1:0] phase_dur(input phase_t p);
    case (p)
      PH_GREEN:  return GREEN_CNT;
      PH_YELLOW: return YELLOW_CNT;
      default:   return RED_CNT;
    endcase
  endfunction

  assign in_flash = (phase_q == PH_FLASH);

  // Night outranks Pause, so the prescaler keeps running in flash mode even
  // with Pause asserted; otherwise the lamp could never blink.
  assign hold = bus.Pause && !bus.Night;

  // The prescaler restarts on every mode change (entering or leaving flash),
  // which is exactly when Night disagrees with the current mode.
  assign clr = bus.Night ^ in_flash;

  sec_tick #(
    .CLK_HZ (CLK_HZ)
  ) u_sec_tick (
    .Sys_CLK (Sys_CLK),
    .Sys_RST (Sys_RST),
    .Hold    (hold),
    .Clr     (clr),
    .Tick    (tick)
  );

  always_ff @(posedge Sys_CLK) begin
    if (Sys_RST) begin
      phase_q <= PH_GREEN;
      cnt_q   <= GREEN_CNT;
      light_q <= LIGHT_GREEN;
      state_q <= 1'b1;
      blink_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      light_q <= light_d;
      state_q <= state_d;
      blink_q <= blink_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    light_d = light_q;
    state_d = state_q;
    blink_d = blink_q;
    nxt     = next_phase(phase_q);

    if (bus.Night) begin
      if (!in_flash) begin
        // Enter flash from any phase: lamp starts lit, display blanked.
        phase_d = PH_FLASH;
        cnt_d   = '0;
        light_d = LIGHT_YELLOW;
        state_d = 1'b0;
        blink_d = 1'b0;
      end else if (tick) begin
        blink_d = !blink_q;
        light_d = blink_q ? LIGHT_YELLOW : LIGHT_OFF;
      end
    end else if (in_flash) begin
      // Leaving night mode always resumes the rotation at RED.
      phase_d = PH_RED;
      cnt_d   = RED_CNT;
      light_d = LIGHT_RED;
      state_d = 1'b1;
      blink_d = 1'b0;
    end else if (tick) begin
      // tick is already masked while paused.
      if (cnt_q > CNT_W'(1)) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        // Load the next phase's full duration on the same edge, so the
        // display runs N..1 and never shows 0 in normal mode.
        phase_d = nxt;
        cnt_d   = phase_dur(nxt);
        light_d = phase_light(nxt);
      end
    end
  end

  assign bus.count    = {{(COUNT_W - CNT_W){1'b0}}, cnt_q};
  assign bus.state    = state_q;
  assign bus.Light    = light_q;
  assign bus.Sec_Tick = tick;

endmodule
